fpu_ret_collect: RTL and testbench
==================================

// Module: fpu_ret_collect
// PURPOSE
//  Downstream of the dual-half FPU: collects the per-lane retire words (u1/u3/u5 ret, ret_en) produced
//  each cycle into one shared FIFO and drains them in order to retirement over a valid/ready port.
//  Accumulates sticky IEEE exception flags from accepted words. Raises an issue-hold credit signal
//  before the FIFO can overflow, because the FPU pipeline cannot stall.
// PARAMETERS
//  DEPTH     8   FIFO entries; power of two, >=4
//  PTR_W     3   log2(DEPTH)
//  HOLD_THR  3   issue_hold asserts when free entries after this cycle < HOLD_THR
// PORTS
//  clk           in   1    clock, rising edge
//  rst           in   1    asynchronous reset, active-low
//  u1_ret        in   14   lane0 retire word: [4:0] flags NV,DZ,OF,UF,NX; [13:5] opaque tag
//  u1_ret_en     in   1    lane0 word valid this cycle
//  u3_ret        in   14   lane1 retire word, same format
//  u3_ret_en     in   1    lane1 valid
//  u5_ret        in   14   lane2 retire word, same format
//  u5_ret_en     in   1    lane2 valid
//  out_ret       out  14   head-of-FIFO word
//  out_lane      out  2    source lane of head word (0=u1,1=u3,2=u5)
//  out_vld       out  1    head word valid
//  out_rdy       in   1    retirement accepts head word
//  issue_hold    out  1    registered; scheduler must stop issuing FP ops
//  flags_clr     in   1    clear sticky flags
//  flags_sticky  out  5    OR of [4:0] of all accepted words since last clear
//  ovf           out  1    sticky: a valid word was dropped; cleared only by reset
// BEHAVIOUR
//  - Reset (rst=0, async): rd/wr pointers=0, count=0, out_vld=0, out_ret=0, out_lane=0,
//    issue_hold=0, flags_sticky=0, ovf=0. FIFO storage is not reset.
//  - Write: n = number of asserted ret_en (0..3). Valid words are compacted in lane order
//    u1,u3,u5 and written at wr, wr+1, wr+2 (mod DEPTH). wr advances by number accepted.
//  - Capacity: free = DEPTH - count at start of cycle; a same-cycle pop does NOT add space.
//    If n > free, the first 'free' words in lane order are accepted, the rest are dropped and
//    ovf is set next cycle. Dropped words never reach the FIFO or the flags.
//  - Read: out_vld = (count != 0); out_ret/out_lane driven combinationally from mem[rd].
//    Pop when out_vld & out_rdy; rd advances by 1 (mod DEPTH). At most one pop per cycle.
//  - Latency: a word presented in cycle N is visible at out_ret no earlier than cycle N+1
//    (no write-to-read bypass, even when empty).
//  - count_next = count + accepted - pop; count range 0..DEPTH (PTR_W+1 bits).
//    Pointers wrap naturally at DEPTH; full = (count==DEPTH), empty = (count==0).
//  - Simultaneous write and pop when full: pop proceeds; incoming words dropped (free=0), ovf set.
//  - issue_hold <= (DEPTH - count_next) < HOLD_THR, updated every cycle.
//  - flags_sticky <= (flags_clr ? 5'b0 : flags_sticky) | OR(accepted words [4:0]);
//    a flag raised in the same cycle as flags_clr survives the clear.
//  - out_rdy with out_vld=0 is ignored. Inputs with ret_en=0 are don't-care.
//  - Reset mid-operation discards all queued words; no partial drain.
// TESTING
//  1 Reset: hold rst=0 with all ret_en=1 -> out_vld=0, issue_hold=0, flags_sticky=0, ovf=0 throughout.
//  2 Ordering: cycle0 u1=0x021,u5=0x040 en, out_rdy=1 -> cycle1 out_ret=0x021 lane0, cycle2
//    out_ret=0x040 lane2, cycle3 out_vld=0; flags_sticky=5'b00001.
//  3 Fill: out_rdy=0, 3 words/cycle for 3 cycles (DEPTH=8) -> after cycle1 issue_hold=1 (free=2),
//    cycle2 accepts 2 (u1,u3), drops u5, ovf=1; count=8, u5 words of cycle2 never appear on output.
//  4 Full+pop: count=8, out_rdy=1, u3_ret_en=1 -> word dropped, ovf=1, count=7 next cycle.
//  5 Flags: flags_clr=1 same cycle as accepted word with [4:0]=5'b10000 -> flags_sticky=5'b10000;
//    next cycle flags_clr=1 alone -> 5'b00000.
//  6 Wrap: stream 20 single words with out_rdy=1 -> output sequence identical, count never >1.

Source files
------------

// File: rtl/fpu_ret_collect.sv
// Retire-word collector: merges up to three FPU lane retire words per cycle into one
// in-order FIFO, drains it over valid/ready, and tracks sticky IEEE flags and overflow.
module fpu_ret_collect #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PTR_W    = 3,
    parameter int unsigned HOLD_THR = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] u1_ret,
    input  logic        u1_ret_en,
    input  logic [13:0] u3_ret,
    input  logic        u3_ret_en,
    input  logic [13:0] u5_ret,
    input  logic        u5_ret_en,
    output logic [13:0] out_ret,
    output logic [1:0]  out_lane,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic        issue_hold,
    input  logic        flags_clr,
    output logic [4:0]  flags_sticky,
    output logic        ovf
);

    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = 14;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned LANES  = 3;

    typedef struct packed {
        logic [1:0]        lane;
        logic [WORD_W-1:0] word;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              hold_q, hold_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              ovf_q, ovf_d;

    logic [WORD_W-1:0] lane_word [LANES];
    logic [LANES-1:0]  lane_en;
    logic [LANES-1:0]  we_c;
    logic [PTR_W-1:0]  waddr_c [LANES];
    entry_t            wdata_c [LANES];
    logic [CNT_W-1:0]  free_c;
    logic [CNT_W-1:0]  acc_c;
    logic [FLAG_W-1:0] acc_flags_c;
    logic              drop_c;
    logic              pop_c;

    assign lane_word[0] = u1_ret;
    assign lane_word[1] = u3_ret;
    assign lane_word[2] = u5_ret;
    assign lane_en      = {u5_ret_en, u3_ret_en, u1_ret_en};

    // Compact valid lanes in order u1,u3,u5 into free slots; space freed by a pop is not reusable this cycle
    always_comb begin
        free_c      = CNT_W'(DEPTH) - count_q;
        acc_c       = '0;
        acc_flags_c = '0;
        drop_c      = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            we_c[l]    = 1'b0;
            waddr_c[l] = '0;
            wdata_c[l] = '0;
            if (lane_en[l]) begin
                if (acc_c < free_c) begin
                    we_c[l]         = 1'b1;
                    waddr_c[l]      = wr_q + PTR_W'(acc_c);
                    wdata_c[l].lane = 2'(l);
                    wdata_c[l].word = lane_word[l];
                    acc_flags_c     = acc_flags_c | lane_word[l][FLAG_W-1:0];
                    acc_c           = acc_c + CNT_W'(1);
                end else begin
                    drop_c = 1'b1;
                end
            end
        end
    end

    assign out_vld  = (count_q != '0);
    assign pop_c    = out_vld & out_rdy;
    assign out_ret  = out_vld ? mem_q[rd_q].word : '0;
    assign out_lane = out_vld ? mem_q[rd_q].lane : '0;

    // Next-state for pointers, occupancy, credit hold and sticky status
    always_comb begin
        wr_d    = wr_q + PTR_W'(acc_c);
        rd_d    = rd_q + PTR_W'(pop_c);
        count_d = count_q + acc_c - CNT_W'(pop_c);
        hold_d  = (CNT_W'(DEPTH) - count_d) < CNT_W'(HOLD_THR);
        flags_d = (flags_clr ? '0 : flags_q) | acc_flags_c;
        ovf_d   = ovf_q | drop_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            hold_q  <= 1'b0;
            flags_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is intentionally unreset; the read side is gated by out_vld
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (we_c[k]) begin
                mem_q[waddr_c[k]] <= wdata_c[k];
            end
        end
    end

    assign issue_hold   = hold_q;
    assign flags_sticky = flags_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_fpu_ret_collect.sv
// Directed bench for fpu_ret_collect: a vector table for ordering, fill, full+pop, flags and
// reset, plus a hand-written streaming sequence that wraps the pointers.
module tb_fpu_ret_collect;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] u1_ret, u3_ret, u5_ret;
    logic        u1_ret_en, u3_ret_en, u5_ret_en;
    logic [13:0] out_ret;
    logic [1:0]  out_lane;
    logic        out_vld;
    logic        out_rdy;
    logic        issue_hold;
    logic        flags_clr;
    logic [4:0]  flags_sticky;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_ret_collect #(.DEPTH(8), .PTR_W(3), .HOLD_THR(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .u1_ret       (u1_ret),
        .u1_ret_en    (u1_ret_en),
        .u3_ret       (u3_ret),
        .u3_ret_en    (u3_ret_en),
        .u5_ret       (u5_ret),
        .u5_ret_en    (u5_ret_en),
        .out_ret      (out_ret),
        .out_lane     (out_lane),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .issue_hold   (issue_hold),
        .flags_clr    (flags_clr),
        .flags_sticky (flags_sticky),
        .ovf          (ovf)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic [2:0]  en;      // {u5,u3,u1}
        logic [13:0] w1, w3, w5;
        logic        rdy;
        logic        clr;
        logic        vld;
        logic [13:0] ret;
        logic [1:0]  lane;
        logic        hold;
        logic [4:0]  flags;
        logic        ovf;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(input string nm, input logic r, input logic [2:0] e,
                                input logic [13:0] a, input logic [13:0] b, input logic [13:0] c,
                                input logic rd, input logic cl, input logic v, input logic [13:0] rt,
                                input logic [1:0] ln, input logic h, input logic [4:0] f, input logic o);
        vec_t t;
        t.name = nm; t.rst_n = r; t.en = e; t.w1 = a; t.w3 = b; t.w5 = c; t.rdy = rd; t.clr = cl;
        t.vld = v; t.ret = rt; t.lane = ln; t.hold = h; t.flags = f; t.ovf = o;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] e, input logic [13:0] a,
                         input logic [13:0] b, input logic [13:0] c, input logic rd, input logic cl);
        @(negedge clk);
        rst = r; u1_ret_en = e[0]; u3_ret_en = e[1]; u5_ret_en = e[2];
        u1_ret = a; u3_ret = b; u5_ret = c; out_rdy = rd; flags_clr = cl;
        @(posedge clk);
        #1;
    endtask

    // {vld, ret, lane, hold, flags, ovf}
    function automatic logic [31:0] pack_out(input logic v, input logic [13:0] rt, input logic [1:0] ln,
                                             input logic h, input logic [4:0] f, input logic o);
        return {8'h0, v, rt, ln, h, f, o};
    endfunction

    initial begin
        logic [13:0] sent [20];
        logic [4:0]  exp_flags;

        rst = 1'b0; u1_ret = '0; u3_ret = '0; u5_ret = '0;
        u1_ret_en = 1'b0; u3_ret_en = 1'b0; u5_ret_en = 1'b0; out_rdy = 1'b0; flags_clr = 1'b0;

        //           name          rst en      w1       w3       w5      rdy clr   vld ret      ln  hold flags    ovf
        vecs[0]  = mk("reset0",    0, 3'b111, 14'h3FF, 14'h3FF, 14'h3FF, 1, 0,   0, 14'h000, 0, 0, 5'b00000, 0);
        vecs[1]  = mk("reset1",    0, 3'b111, 14'h01F, 14'h01F, 14'h01F, 1, 0,   0, 14'h000, 0, 0, 5'b00000, 0);
        vecs[2]  = mk("order_w",   1, 3'b101, 14'h021, 14'h000, 14'h040, 1, 0,   1, 14'h021, 0, 0, 5'b00001, 0);
        vecs[3]  = mk("order_p1",  1, 3'b000, 14'h000, 14'h000, 14'h000, 1, 0,   1, 14'h040, 2, 0, 5'b00001, 0);
        vecs[4]  = mk("order_p2",  1, 3'b000, 14'h000, 14'h000, 14'h000, 1, 0,   0, 14'h000, 0, 0, 5'b00001, 0);
        vecs[5]  = mk("fill_c0",   1, 3'b111, 14'h100, 14'h120, 14'h140, 0, 0,   1, 14'h100, 0, 0, 5'b00001, 0);
        vecs[6]  = mk("fill_c1",   1, 3'b111, 14'h160, 14'h180, 14'h1A0, 0, 0,   1, 14'h100, 0, 1, 5'b00001, 0);
        vecs[7]  = mk("fill_c2",   1, 3'b111, 14'h1C0, 14'h1E0, 14'h21F, 0, 0,   1, 14'h100, 0, 1, 5'b00001, 1);
        vecs[8]  = mk("full_pop",  1, 3'b010, 14'h000, 14'h3FF, 14'h000, 1, 0,   1, 14'h120, 1, 1, 5'b00001, 1);
        vecs[9]  = mk("drain1",    1, 3'b000, 14'h000, 14'h000, 14'h000, 1, 0,   1, 14'h140, 2, 1, 5'b00001, 1);
        vecs[10] = mk("drain2",    1, 3'b000, 14'h000, 14'h000, 14'h000, 1, 0,   1, 14'h160, 0, 0, 5'b00001, 1);
        vecs[11] = mk("drain3",    1, 3'b000, 14'h000, 14'h000, 14'h000, 1, 0,   1, 14'h180, 1, 0, 5'b00001, 1);
        vecs[12] = mk("drain4",    1, 3'b000, 14'h000, 14'h000, 14'h000, 1, 0,   1, 14'h1A0, 2, 0, 5'b00001, 1);
        vecs[13] = mk("drain5",    1, 3'b000, 14'h000, 14'h000, 14'h000, 1, 0,   1, 14'h1C0, 0, 0, 5'b00001, 1);
        vecs[14] = mk("drain6",    1, 3'b000, 14'h000, 14'h000, 14'h000, 1, 0,   1, 14'h1E0, 1, 0, 5'b00001, 1);
        vecs[15] = mk("drain_end", 1, 3'b000, 14'h000, 14'h000, 14'h000, 1, 0,   0, 14'h000, 0, 0, 5'b00001, 1);
        vecs[16] = mk("clr_raise", 1, 3'b001, 14'h010, 14'h000, 14'h000, 1, 1,   1, 14'h010, 0, 0, 5'b10000, 1);
        vecs[17] = mk("clr_alone", 1, 3'b000, 14'h000, 14'h000, 14'h000, 1, 1,   0, 14'h000, 0, 0, 5'b00000, 1);
        vecs[18] = mk("pre_rst",   1, 3'b011, 14'h0A2, 14'h0C4, 14'h000, 0, 0,   1, 14'h0A2, 0, 0, 5'b00110, 1);
        vecs[19] = mk("mid_rst",   0, 3'b000, 14'h000, 14'h000, 14'h000, 0, 0,   0, 14'h000, 0, 0, 5'b00000, 0);
        vecs[20] = mk("post_rst",  1, 3'b000, 14'h000, 14'h000, 14'h000, 1, 0,   0, 14'h000, 0, 0, 5'b00000, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].w1, vecs[i].w3, vecs[i].w5, vecs[i].rdy, vecs[i].clr);
            check(vecs[i].name,
                  pack_out(out_vld, out_ret, out_lane, issue_hold, flags_sticky, ovf),
                  pack_out(vecs[i].vld, vecs[i].ret, vecs[i].lane, vecs[i].hold, vecs[i].flags, vecs[i].ovf));
        end

        // Streaming single words across several pointer wraps with a ready consumer
        exp_flags = '0;
        for (int i = 0; i < 20; i++) begin
            logic [2:0]  en;
            logic [13:0] w;
            logic [1:0]  ln;
            w  = 14'(i * 389 + 7);
            ln = 2'(i % 3);
            en = 3'b001 << ln;
            sent[i] = w;
            exp_flags = exp_flags | w[4:0];
            drive(1'b1, en, w, w, w, 1'b1, 1'b0);
            check($sformatf("wrap_word%0d", i), {16'h0, out_vld, out_lane, out_ret}, {16'h0, 1'b1, ln, sent[i]});
            check($sformatf("wrap_hold%0d", i), {31'h0, issue_hold}, 32'h0);
        end
        drive(1'b1, 3'b000, 14'h0, 14'h0, 14'h0, 1'b1, 1'b0);
        check("wrap_empty", {31'h0, out_vld}, 32'h0);
        check("wrap_flags", {27'h0, flags_sticky}, {27'h0, exp_flags});
        check("wrap_ovf", {31'h0, ovf}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
